// File: rtl/blk_15c3c0.sv
// Traffic initiator for a 1r1w synchronous byte-masked memory: fill, masked overwrite, read-back compare.
// Define BSG_MEM_TESTER_RAW_CHECK_EN to add a same-address read/write collision phase before the drain.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start_i; results of last run held
//   S_FILL  | full-word write of P(a) to every address
//   S_MASK  | byte-masked write of ~P(a) under M(a), leaving E(a) in memory
//   S_CHECK | read every address, compare one cycle later against E(a)
//   S_RAW   | read and write the same address together, expect new data ~E(a)
//   S_DRAIN | last read's compare completes
//   S_DONE  | one-cycle done pulse, pass/fail published
module blk_15c3c0 #(
    parameter int width_p = 64,
    parameter int els_p = 16,
    parameter int err_width_p = 16,
    localparam int data_width_in_bytes_lp = width_p >> 3,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              start_i,
    input  logic [7:0]                        seed_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              pass_o,
    output logic [err_width_p-1:0]            error_count_o,
    output logic [addr_width_lp-1:0]          first_err_addr_o,
    output logic                              r_v_o,
    output logic [addr_width_lp-1:0]          r_addr_o,
    output logic                              w_v_o,
    output logic [addr_width_lp-1:0]          w_addr_o,
    output logic [width_p-1:0]                w_data_o,
    output logic [data_width_in_bytes_lp-1:0] w_mask_o,
    input  logic [width_p-1:0]                data_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_MASK,
        S_CHECK,
        S_RAW,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    state_e                     state_r, state_nxt;
    logic [addr_width_lp-1:0]   addr_r, addr_nxt, addr_inc;
    logic                       addr_last;
    logic [7:0]                 seed_r, seed_nxt;

    logic                       pipe_v_r;
    logic                       pipe_raw_r;
    logic [addr_width_lp-1:0]   pipe_addr_r;

    logic [width_p-1:0]         cmp_data;
    logic                       mismatch;
    logic [err_width_p-1:0]     err_nxt;
    logic [addr_width_lp-1:0]   first_err_nxt;

    logic [width_p-1:0]                pat_nxt;
    logic [width_p-1:0]                exp_nxt;
    logic [data_width_in_bytes_lp-1:0] mask_nxt;

    // Byte k of word a is (seed + a*bytes + k) mod 256, summed at full width first.
    function automatic logic [width_p-1:0] pattern_word(input logic [7:0] s,
                                                         input logic [addr_width_lp-1:0] a);
        logic [31:0]        base;
        logic [width_p-1:0] w;
        base = 32'(s) + 32'(a) * 32'(data_width_in_bytes_lp);
        w = '0;
        for (int k = 0; k < data_width_in_bytes_lp; k++) begin
            w[8*k +: 8] = 8'(base + 32'(k));
        end
        return w;
    endfunction

    function automatic logic [data_width_in_bytes_lp-1:0] mask_word(input logic [addr_width_lp-1:0] a);
        logic [data_width_in_bytes_lp-1:0] m;
        m = '0;
        for (int k = 0; k < data_width_in_bytes_lp; k++) begin
            m[k] = ((k % 2) == 0) ^ a[0];
        end
        return m;
    endfunction

    function automatic logic [width_p-1:0] expect_word(input logic [7:0] s,
                                                        input logic [addr_width_lp-1:0] a);
        logic [width_p-1:0]                p;
        logic [data_width_in_bytes_lp-1:0] m;
        logic [width_p-1:0]                e;
        p = pattern_word(s, a);
        m = mask_word(a);
        e = '0;
        for (int k = 0; k < data_width_in_bytes_lp; k++) begin
            e[8*k +: 8] = m[k] ? ~p[8*k +: 8] : p[8*k +: 8];
        end
        return e;
    endfunction

    assign addr_last = (addr_r == last_addr_lp);
    assign addr_inc  = addr_last ? '0 : addr_r + addr_width_lp'(1);

    always_comb begin
        state_nxt = state_r;
        addr_nxt  = addr_r;
        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = S_FILL;
                    addr_nxt  = '0;
                end
            end
            S_FILL: begin
                addr_nxt = addr_inc;
                if (addr_last) state_nxt = S_MASK;
            end
            S_MASK: begin
                addr_nxt = addr_inc;
                if (addr_last) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                addr_nxt = addr_inc;
                if (addr_last) begin
`ifdef BSG_MEM_TESTER_RAW_CHECK_EN
                    state_nxt = S_RAW;
`else
                    state_nxt = S_DRAIN;
`endif
                end
            end
            S_RAW: begin
                addr_nxt = addr_inc;
                if (addr_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                state_nxt = S_DONE;
                addr_nxt  = '0;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The seed must already be the new one for the first FILL word driven at the start edge.
    assign seed_nxt = (state_r == S_IDLE && start_i) ? seed_i : seed_r;
    assign pat_nxt  = pattern_word(seed_nxt, addr_nxt);
    assign exp_nxt  = expect_word(seed_nxt, addr_nxt);
    assign mask_nxt = mask_word(addr_nxt);

    assign cmp_data = pipe_raw_r ? ~expect_word(seed_r, pipe_addr_r) : expect_word(seed_r, pipe_addr_r);
    assign mismatch = pipe_v_r && (data_i != cmp_data);
    assign err_nxt  = (mismatch && (error_count_o != '1)) ? error_count_o + err_width_p'(1)
                                                          : error_count_o;
    assign first_err_nxt = (mismatch && (error_count_o == '0)) ? pipe_addr_r : first_err_addr_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r          <= S_IDLE;
            addr_r           <= '0;
            seed_r           <= '0;
            pipe_v_r         <= 1'b0;
            pipe_raw_r       <= 1'b0;
            pipe_addr_r      <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            error_count_o    <= '0;
            first_err_addr_o <= '0;
            r_v_o            <= 1'b0;
            r_addr_o         <= '0;
            w_v_o            <= 1'b0;
            w_addr_o         <= '0;
            w_data_o         <= '0;
            w_mask_o         <= '0;
        end else begin
            state_r          <= state_nxt;
            addr_r           <= addr_nxt;
            seed_r           <= seed_nxt;
            pipe_v_r         <= r_v_o;
            pipe_addr_r      <= r_addr_o;
            pipe_raw_r       <= r_v_o & w_v_o;
            error_count_o    <= err_nxt;
            first_err_addr_o <= first_err_nxt;
            done_o           <= 1'b0;
            r_v_o            <= 1'b0;
            r_addr_o         <= '0;
            w_v_o            <= 1'b0;
            w_addr_o         <= '0;
            w_data_o         <= '0;
            w_mask_o         <= '0;

            if (state_r == S_IDLE && start_i) begin
                busy_o           <= 1'b1;
                pass_o           <= 1'b0;
                error_count_o    <= '0;
                first_err_addr_o <= '0;
            end

            // Bus outputs are registered from the next state so they line up with it.
            case (state_nxt)
                S_FILL: begin
                    w_v_o    <= 1'b1;
                    w_addr_o <= addr_nxt;
                    w_data_o <= pat_nxt;
                    w_mask_o <= '1;
                end
                S_MASK: begin
                    w_v_o    <= 1'b1;
                    w_addr_o <= addr_nxt;
                    w_data_o <= ~pat_nxt;
                    w_mask_o <= mask_nxt;
                end
                S_CHECK: begin
                    r_v_o    <= 1'b1;
                    r_addr_o <= addr_nxt;
                end
                S_RAW: begin
                    r_v_o    <= 1'b1;
                    r_addr_o <= addr_nxt;
                    w_v_o    <= 1'b1;
                    w_addr_o <= addr_nxt;
                    w_data_o <= ~exp_nxt;
                    w_mask_o <= '1;
                end
                S_DONE: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    pass_o <= (err_nxt == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blk_15c3c0.sv
// Bench for blk_15c3c0: ideal masked 1r1w memory with injectable read corruption, cycle schedule checks.
module tb_blk_15c3c0;

    localparam int W  = 32;
    localparam int E  = 4;
    localparam int AW = 2;
    localparam int NB = 4;
    localparam int ES = 8;
`ifdef BSG_MEM_TESTER_RAW_CHECK_EN
    localparam int RAW_LEN   = E;
    localparam int RAW_LEN_S = ES;
`else
    localparam int RAW_LEN   = 0;
    localparam int RAW_LEN_S = 0;
`endif
    localparam int DONE_CYC   = 3*E + 2 + RAW_LEN;
    localparam int DONE_CYC_S = 3*ES + 2 + RAW_LEN_S;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          start;
    logic [7:0]    seed;
    logic          busy, done, pass;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_err;
    logic          r_v, w_v;
    logic [AW-1:0] r_addr, w_addr;
    logic [W-1:0]  w_data, data;
    logic [NB-1:0] w_mask;

    logic          start_s;
    logic          busy_s, done_s, pass_s;
    logic [1:0]    err_cnt_s;
    logic [2:0]    first_err_s, r_addr_s, w_addr_s;
    logic          r_v_s, w_v_s;
    logic [W-1:0]  w_data_s;
    logic [NB-1:0] w_mask_s;
    logic [W-1:0]  zero_data;

    int checks = 0;
    int failures = 0;

    blk_15c3c0 #(.width_p(W), .els_p(E), .err_width_p(16)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .seed_i(seed),
        .busy_o(busy), .done_o(done), .pass_o(pass), .error_count_o(err_cnt),
        .first_err_addr_o(first_err), .r_v_o(r_v), .r_addr_o(r_addr),
        .w_v_o(w_v), .w_addr_o(w_addr), .w_data_o(w_data), .w_mask_o(w_mask),
        .data_i(data)
    );

    blk_15c3c0 #(.width_p(W), .els_p(ES), .err_width_p(2)) dut_s (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start_s), .seed_i(seed),
        .busy_o(busy_s), .done_o(done_s), .pass_o(pass_s), .error_count_o(err_cnt_s),
        .first_err_addr_o(first_err_s), .r_v_o(r_v_s), .r_addr_o(r_addr_s),
        .w_v_o(w_v_s), .w_addr_o(w_addr_s), .w_data_o(w_data_s), .w_mask_o(w_mask_s),
        .data_i(zero_data)
    );

    // Ideal memory with read-through on collisions; corrupt[] is XORed into read data.
    logic [W-1:0] mem [E];
    logic [W-1:0] corrupt [E];

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] nw,
                                           input logic [NB-1:0] m);
        logic [W-1:0] r;
        r = old;
        for (int k = 0; k < NB; k++) if (m[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (w_v) mem[w_addr] <= merge(mem[w_addr], w_data, w_mask);
        if (r_v) data <= ((w_v && w_addr == r_addr) ? merge(mem[r_addr], w_data, w_mask)
                                                    : mem[r_addr]) ^ corrupt[r_addr];
    end

    function automatic logic [W-1:0] ref_p(input int s, input int a);
        logic [W-1:0] p;
        for (int k = 0; k < NB; k++) p[8*k +: 8] = 8'((s + a*NB + k) % 256);
        return p;
    endfunction

    function automatic logic [NB-1:0] ref_m(input int a);
        logic [NB-1:0] m;
        for (int k = 0; k < NB; k++) m[k] = (((k + a) % 2) == 0);
        return m;
    endfunction

    function automatic logic [W-1:0] ref_e(input int s, input int a);
        logic [W-1:0] p, e;
        logic [NB-1:0] m;
        p = ref_p(s, a);
        m = ref_m(a);
        for (int k = 0; k < NB; k++) e[8*k +: 8] = m[k] ? ~p[8*k +: 8] : p[8*k +: 8];
        return e;
    endfunction

    // {busy, done, r_v, r_addr, w_v, w_addr, w_data, w_mask}
    function automatic logic [43:0] sched(input int s, input int cyc);
        logic b, d, rv, wv;
        logic [AW-1:0] ra, wa;
        logic [W-1:0] wd;
        logic [NB-1:0] wm;
        b = 1'b1; d = 1'b0; rv = 1'b0; wv = 1'b0; ra = '0; wa = '0; wd = '0; wm = '0;
        if (cyc <= E) begin
            wv = 1'b1; wa = AW'(cyc - 1); wd = ref_p(s, cyc - 1); wm = '1;
        end else if (cyc <= 2*E) begin
            wv = 1'b1; wa = AW'(cyc - E - 1); wd = ~ref_p(s, cyc - E - 1); wm = ref_m(cyc - E - 1);
        end else if (cyc <= 3*E) begin
            rv = 1'b1; ra = AW'(cyc - 2*E - 1);
        end else if (cyc <= 3*E + RAW_LEN) begin
            rv = 1'b1; ra = AW'(cyc - 3*E - 1);
            wv = 1'b1; wa = ra; wd = ~ref_e(s, cyc - 3*E - 1); wm = '1;
        end else if (cyc == DONE_CYC) begin
            b = 1'b0; d = 1'b1;
        end else if (cyc > DONE_CYC) begin
            b = 1'b0;
        end
        return {b, d, rv, ra, wv, wa, wd, wm};
    endfunction

    function automatic logic [43:0] observed();
        return {busy, done, r_v, r_addr, w_v, w_addr, w_data, w_mask};
    endfunction

    task automatic run_check(input logic [7:0] s, input string tag);
        int nerr, first;
        logic [43:0] got, exp;
        nerr = 0; first = -1;
        for (int a = 0; a < E; a++) begin
            if (corrupt[a] != '0) begin
                nerr += (RAW_LEN > 0) ? 2 : 1;
                if (first < 0) first = a;
            end
        end
        if (first < 0) first = 0;
        @(negedge clk);
        start = 1'b1;
        seed = s;
        for (int cyc = 1; cyc <= DONE_CYC + 1; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            got = observed();
            exp = sched(int'(s), cyc);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s sched cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
            end
            if (cyc == DONE_CYC || cyc == DONE_CYC + 1) begin
                checks++;
                if ({pass, err_cnt, first_err} !== {(nerr == 0), 16'(nerr), AW'(first)}) begin
                    failures++;
                    $display("FAIL %s result cyc=%0d got pass=%0b err=%0d first=%0d exp pass=%0b err=%0d first=%0d",
                             tag, cyc, pass, err_cnt, first_err, (nerr == 0), nerr, first);
                end
            end
        end
    endtask

    task automatic clear_corrupt();
        for (int a = 0; a < E; a++) corrupt[a] = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        start_s = 1'b0;
        seed = 8'h00;
        #1;
        checks++;
        if ({observed(), pass, err_cnt, first_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {observed(), pass, err_cnt, first_err});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({observed(), pass} !== '0) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=0", {observed(), pass});
        end
    endtask

    task automatic test_known();
        logic [W-1:0] inv;
        clear_corrupt();
        run_check(8'h10, "known_seed10");
        inv = (RAW_LEN > 0) ? '1 : '0;
        checks++;
        if ({mem[0], mem[1]} !== {32'h13ED11EF ^ inv, 32'hE816EA14 ^ inv}) begin
            failures++;
            $display("FAIL known_mem got=%h_%h exp=%h_%h", mem[0], mem[1],
                     32'h13ED11EF ^ inv, 32'hE816EA14 ^ inv);
        end
    endtask

    task automatic test_corrupt_addr2();
        clear_corrupt();
        corrupt[2] = 32'h1;
        run_check(8'h10, "corrupt_addr2");
        clear_corrupt();
    endtask

    task automatic test_random_runs();
        for (int i = 0; i < 6; i++) begin
            clear_corrupt();
            for (int a = 0; a < E; a++)
                if ($urandom_range(2, 0) == 0) corrupt[a] = 32'h1 << $urandom_range(31, 0);
            run_check(8'($urandom), $sformatf("random_%0d", i));
        end
        clear_corrupt();
    endtask

    task automatic test_hold_start();
        int dones;
        bit seen;
        dones = 0;
        @(negedge clk);
        start = 1'b1;
        seed = 8'hA5;
        for (int cyc = 1; cyc <= DONE_CYC + 2; cyc++) begin
            @(negedge clk);
            if (done) dones++;
            if (cyc == DONE_CYC + 1) begin
                checks++;
                if ({busy, w_v, r_v} !== 3'b000) begin
                    failures++;
                    $display("FAIL hold_idle_gap got=%b exp=000", {busy, w_v, r_v});
                end
            end
            if (cyc == DONE_CYC + 2) begin
                checks++;
                if ({busy, w_v, w_addr, w_data} !== {1'b1, 1'b1, AW'(0), ref_p(8'hA5, 0)}) begin
                    failures++;
                    $display("FAIL hold_restart got=%h exp=%h", {busy, w_v, w_addr, w_data},
                             {1'b1, 1'b1, AW'(0), ref_p(8'hA5, 0)});
                end
            end
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL hold_done_pulses got=%0d exp=1", dones);
        end
        start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen || !pass) begin
            failures++;
            $display("FAIL hold_second_run got seen=%0b pass=%0b exp seen=1 pass=1", seen, pass);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
        seed = 8'($urandom);
        for (int cyc = 1; cyc <= E + 2; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({observed(), pass, err_cnt, first_err} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%h exp=0", {observed(), pass, err_cnt, first_err});
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, r_v, w_v, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_idle got=%b exp=0000", {busy, r_v, w_v, done});
        end
        run_check(8'($urandom), "after_reset");
    endtask

    task automatic test_saturate();
        int cyc_done;
        cyc_done = -1;
        @(negedge clk);
        start_s = 1'b1;
        seed = 8'($urandom);
        for (int cyc = 1; cyc <= DONE_CYC_S + 20 && cyc_done < 0; cyc++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (done_s) cyc_done = cyc;
        end
        checks++;
        if (cyc_done != DONE_CYC_S) begin
            failures++;
            $display("FAIL sat_done_cycle got=%0d exp=%0d", cyc_done, DONE_CYC_S);
        end
        checks++;
        if ({pass_s, err_cnt_s, first_err_s} !== {1'b0, 2'd3, 3'd0}) begin
            failures++;
            $display("FAIL sat_result got pass=%0b err=%0d first=%0d exp pass=0 err=3 first=0",
                     pass_s, err_cnt_s, first_err_s);
        end
    endtask

    initial begin
        zero_data = '0;
        data = '0;
        for (int a = 0; a < E; a++) mem[a] = '0;
        clear_corrupt();
        test_reset();
        test_known();
        test_corrupt_addr2();
        test_random_runs();
        test_hold_start();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
